// File: rtl/frame_pkg.sv
// Shared definitions for the delay-tester frame sender and receiver:
// receiver state encoding, header field lengths, EtherTypes and default MACs.
package frame_pkg;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_MAC_DST     = 4'd1,
    S_MAC_SRC     = 4'd2,
    S_ETH_TYPE    = 4'd3,
    S_SEQ         = 4'd4,
    S_TSTAMP      = 4'd5,
    S_PAYLOAD     = 4'd6,
    S_DROP        = 4'd7,
    S_WAIT_STATUS = 4'd8
  } rx_state_t;

  localparam int MAC_LEN          = 6;
  localparam int TYPE_LEN         = 2;
  localparam int SEQ_LEN_DEFAULT  = 2;
  localparam int TS_LEN_DEFAULT   = 4;
  localparam int CNT_W            = 4;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETH_TYPE_RARP = 16'h8035;
  localparam logic [15:0] ETH_TYPE_IPV6 = 16'h86DD;
  localparam logic [15:0] ETH_TYPE_TEST = 16'h88B5;

  localparam logic [47:0] MAC_LOCAL_DEFAULT = 48'h004e46324301;
  localparam logic [47:0] MAC_PEER_DEFAULT  = 48'h004e46324300;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rx_field_shift.sv
// Byte-wide shift register capturing one header field MSB-first; reports the
// last byte of the field and whether the field (including the current byte) matches.
module rx_field_shift
  import frame_pkg::*;
#(
  parameter int                  NBYTES = MAC_LEN,
  parameter logic [8*NBYTES-1:0] MATCH  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [CNT_W-1:0]      idx,
  input  logic [7:0]            data,
  output logic [8*NBYTES-1:0]   value,
  output logic                  last,
  output logic                  hit
);

  logic [8*NBYTES-1:0] value_nxt;

  // compare against the value as it will be once this byte is shifted in,
  // so the decision can be taken on the field's final byte
  assign value_nxt = {value[8*NBYTES-9:0], data};
  assign last      = (idx == CNT_W'(NBYTES - 1));
  assign hit       = (value_nxt == MATCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  value <= '0;
    else if (en) value <= value_nxt;
  end

endmodule

// File: rtl/frame_receiver.sv
// Delay-tester receive side: parses/filters the MAC RX byte stream and reports one-way delay.
// Define RX_SRC_FILTER_EN to also require the source MAC to equal MAC_PEER_ADDR.
//
// state         | meaning
// IDLE          | waiting for the first byte of a frame
// MAC_DST       | capturing destination MAC
// MAC_SRC       | capturing source MAC
// ETH_TYPE      | capturing EtherType
// SEQ           | capturing sequence number
// TSTAMP        | capturing transmit timestamp
// PAYLOAD       | swallowing remaining bytes of an accepted frame
// DROP          | swallowing remaining bytes of a filtered frame
// WAIT_STATUS   | waiting for good/bad frame status or timeout
module frame_receiver
  import frame_pkg::*;
#(
  parameter logic [47:0] MAC_LOCAL_ADDR = MAC_LOCAL_DEFAULT,
  parameter logic [47:0] MAC_PEER_ADDR  = MAC_PEER_DEFAULT,
  parameter logic [15:0] TEST_ETH_TYPE  = ETH_TYPE_TEST,
  parameter int          TS_WIDTH       = 32,
  parameter int          SEQ_WIDTH      = 16,
  parameter int          STATUS_TIMEOUT = 16
) (
  input  logic                 rx_clk,
  input  logic                 reset_n,
  input  logic [7:0]           mac_rx_data,
  input  logic                 mac_rx_dvld,
  input  logic                 mac_rx_goodframe,
  input  logic                 mac_rx_badframe,
  input  logic [TS_WIDTH-1:0]  local_time,
  output logic [TS_WIDTH-1:0]  delay_value,
  output logic [SEQ_WIDTH-1:0] delay_seq,
  output logic                 delay_valid,
  output logic [15:0]          cnt_ok,
  output logic [15:0]          cnt_drop,
  output logic [15:0]          cnt_bad
);

  localparam int SEQ_BYTES = SEQ_WIDTH / 8;
  localparam int TS_BYTES  = TS_WIDTH / 8;
  localparam int TMR_W     = $clog2(STATUS_TIMEOUT + 1);

  logic [7:0]          data_r;
  logic                dvld_r, good_r, bad_r;
  logic [TS_WIDTH-1:0] time_r;

  rx_state_t           state, state_nxt, field_next;
  logic [CNT_W-1:0]    cnt;
  logic [TMR_W-1:0]    timer;
  logic                drop_flag;
  logic [TS_WIDTH-1:0] t_arrival;

  logic frame_start, drop_set, ev_ok, ev_drop, ev_bad;
  logic field_last, field_reject, tmr_zero;

  logic [47:0]          dst_value, src_value;
  logic [15:0]          type_value;
  logic [SEQ_WIDTH-1:0] seq_value;
  logic [TS_WIDTH-1:0]  ts_value;
  logic dst_last, dst_hit, src_last, src_hit, type_last, type_hit;
  logic seq_last, seq_hit, ts_last, ts_hit;
  logic unused_sink;

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r <= '0;
      dvld_r <= 1'b0;
      good_r <= 1'b0;
      bad_r  <= 1'b0;
      time_r <= '0;
    end else begin
      data_r <= mac_rx_data;
      dvld_r <= mac_rx_dvld;
      good_r <= mac_rx_goodframe;
      bad_r  <= mac_rx_badframe;
      time_r <= local_time;
    end
  end

  rx_field_shift #(.NBYTES(MAC_LEN), .MATCH(MAC_LOCAL_ADDR)) u_dst (
    .clk(rx_clk), .rst_n(reset_n), .en(dvld_r && (frame_start || state == S_MAC_DST)),
    .idx(cnt), .data(data_r), .value(dst_value), .last(dst_last), .hit(dst_hit));

  rx_field_shift #(.NBYTES(MAC_LEN), .MATCH(MAC_PEER_ADDR)) u_src (
    .clk(rx_clk), .rst_n(reset_n), .en(dvld_r && state == S_MAC_SRC),
    .idx(cnt), .data(data_r), .value(src_value), .last(src_last), .hit(src_hit));

  rx_field_shift #(.NBYTES(TYPE_LEN), .MATCH(TEST_ETH_TYPE)) u_type (
    .clk(rx_clk), .rst_n(reset_n), .en(dvld_r && state == S_ETH_TYPE),
    .idx(cnt), .data(data_r), .value(type_value), .last(type_last), .hit(type_hit));

  rx_field_shift #(.NBYTES(SEQ_BYTES)) u_seq (
    .clk(rx_clk), .rst_n(reset_n), .en(dvld_r && state == S_SEQ),
    .idx(cnt), .data(data_r), .value(seq_value), .last(seq_last), .hit(seq_hit));

  rx_field_shift #(.NBYTES(TS_BYTES)) u_ts (
    .clk(rx_clk), .rst_n(reset_n), .en(dvld_r && state == S_TSTAMP),
    .idx(cnt), .data(data_r), .value(ts_value), .last(ts_last), .hit(ts_hit));

`ifdef RX_SRC_FILTER_EN
  assign unused_sink = ^{seq_hit, ts_hit, dst_value, src_value, type_value};
`else
  assign unused_sink = ^{seq_hit, ts_hit, src_hit, dst_value, src_value, type_value};
`endif

  always_comb begin
    field_last   = 1'b0;
    field_reject = 1'b0;
    field_next   = S_PAYLOAD;
    case (state)
      S_MAC_DST: begin
        field_last   = dst_last;
        field_reject = !dst_hit;
        field_next   = S_MAC_SRC;
      end
      S_MAC_SRC: begin
        field_last   = src_last;
`ifdef RX_SRC_FILTER_EN
        field_reject = !src_hit;
`endif
        field_next   = S_ETH_TYPE;
      end
      S_ETH_TYPE: begin
        field_last   = type_last;
        field_reject = !type_hit;
        field_next   = S_SEQ;
      end
      S_SEQ: begin
        field_last = seq_last;
        field_next = S_TSTAMP;
      end
      S_TSTAMP: begin
        field_last = ts_last;
        field_next = S_PAYLOAD;
      end
      default: ;
    endcase
  end

  assign tmr_zero = (timer == '0);

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    drop_set    = 1'b0;
    ev_ok       = 1'b0;
    ev_drop     = 1'b0;
    ev_bad      = 1'b0;
    case (state)
      S_IDLE: begin
        if (dvld_r) begin
          state_nxt   = S_MAC_DST;
          frame_start = 1'b1;
        end
      end
      S_MAC_DST, S_MAC_SRC, S_ETH_TYPE, S_SEQ, S_TSTAMP: begin
        if (!dvld_r) begin
          state_nxt = S_WAIT_STATUS;
          drop_set  = 1'b1;
        end else if (field_last) begin
          if (field_reject) begin
            state_nxt = S_DROP;
            drop_set  = 1'b1;
          end else begin
            state_nxt = field_next;
          end
        end
      end
      S_PAYLOAD, S_DROP: begin
        if (!dvld_r) state_nxt = S_WAIT_STATUS;
      end
      S_WAIT_STATUS: begin
        if (bad_r)                  ev_bad  = 1'b1;
        else if (good_r)            begin ev_ok = !drop_flag; ev_drop = drop_flag; end
        else if (dvld_r || tmr_zero) ev_drop = 1'b1;
        // a new frame arriving before status closes the old one but keeps its first byte
        if (dvld_r) begin
          state_nxt   = S_MAC_DST;
          frame_start = 1'b1;
        end else if (bad_r || good_r || tmr_zero) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      timer     <= '0;
      drop_flag <= 1'b0;
      t_arrival <= '0;
    end else begin
      state <= state_nxt;
      // the byte that opens a frame is already destination byte 0
      if (frame_start)             cnt <= CNT_W'(1);
      else if (state_nxt != state) cnt <= '0;
      else if (dvld_r)             cnt <= cnt + CNT_W'(1);

      if (state_nxt == S_WAIT_STATUS && state != S_WAIT_STATUS)
        timer <= TMR_W'(STATUS_TIMEOUT - 1);
      else if (state == S_WAIT_STATUS && !tmr_zero)
        timer <= timer - TMR_W'(1);

      if (frame_start)   drop_flag <= 1'b0;
      else if (drop_set) drop_flag <= 1'b1;

      if (frame_start) t_arrival <= time_r;
    end
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      delay_value <= '0;
      delay_seq   <= '0;
      delay_valid <= 1'b0;
      cnt_ok      <= '0;
      cnt_drop    <= '0;
      cnt_bad     <= '0;
    end else begin
      delay_valid <= ev_ok;
      if (ev_ok) begin
        delay_value <= t_arrival - ts_value;
        delay_seq   <= seq_value;
        cnt_ok      <= sat_inc(cnt_ok);
      end
      if (ev_drop) cnt_drop <= sat_inc(cnt_drop);
      if (ev_bad)  cnt_bad  <= sat_inc(cnt_bad);
    end
  end

endmodule

// File: tb/tb_frame_receiver.sv
// Bench for frame_receiver: directed scenarios plus randomized frames scored
// against a frame-level reference model.
module tb_frame_receiver;

  localparam logic [47:0] LOCAL = 48'h004e46324301;
  localparam logic [47:0] PEER  = 48'h004e46324300;
  localparam int ST_GOOD = 0, ST_BAD = 1, ST_BOTH = 2, ST_NONE = 3;

  typedef logic [7:0] u8_t;

  logic        rx_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  mac_rx_data = '0;
  logic        mac_rx_dvld = 1'b0;
  logic        mac_rx_goodframe = 1'b0;
  logic        mac_rx_badframe = 1'b0;
  logic [31:0] local_time = '0;
  logic [31:0] delay_value;
  logic [15:0] delay_seq;
  logic        delay_valid;
  logic [15:0] cnt_ok, cnt_drop, cnt_bad;

  int n_vec = 0;
  int n_err = 0;
  int pulses = 0;

  u8_t         frm[$];
  logic [15:0] m_ok, m_drop, m_bad, m_dseq;
  logic [31:0] m_dval;

  frame_receiver dut (
    .rx_clk(rx_clk), .reset_n(reset_n), .mac_rx_data(mac_rx_data),
    .mac_rx_dvld(mac_rx_dvld), .mac_rx_goodframe(mac_rx_goodframe),
    .mac_rx_badframe(mac_rx_badframe), .local_time(local_time),
    .delay_value(delay_value), .delay_seq(delay_seq), .delay_valid(delay_valid),
    .cnt_ok(cnt_ok), .cnt_drop(cnt_drop), .cnt_bad(cnt_bad));

  always #5 rx_clk = ~rx_clk;

  always @(negedge rx_clk) if (delay_valid) pulses = pulses + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rx_clk);
    #1;
    local_time = local_time + 32'd1;
  endtask

  function automatic void put(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
  endfunction

  function automatic logic [63:0] field(input int off, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = (v << 8) | 64'(frm[off + i]);
    return v;
  endfunction

  task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                       input logic [15:0] seq, input logic [31:0] ts, input int plen);
    frm.delete();
    put(dst, 6); put(src, 6); put(typ, 2); put(seq, 2); put(ts, 4);
    for (int i = 0; i < plen; i++) frm.push_back(u8_t'($urandom));
  endtask

  // Frame-level outcome: header fully present and filters pass, then status decides.
  function automatic int model(input int status, input logic [31:0] lt0);
    bit pass;
    pass = (frm.size() >= 20);
    if (pass) begin
      pass = (field(0, 6) == 64'(LOCAL)) && (field(12, 2) == 64'h88B5);
`ifdef RX_SRC_FILTER_EN
      pass = pass && (field(6, 6) == 64'(PEER));
`endif
    end
    if (status == ST_BAD || status == ST_BOTH) begin
      if (m_bad != 16'hFFFF) m_bad++;
    end else if (status == ST_GOOD && pass) begin
      if (m_ok != 16'hFFFF) m_ok++;
      m_dval = lt0 - 32'(field(16, 4));
      m_dseq = 16'(field(14, 2));
      return 1;
    end else begin
      if (m_drop != 16'hFFFF) m_drop++;
    end
    return 0;
  endfunction

  task automatic model_clear();
    m_ok = 0; m_drop = 0; m_bad = 0; m_dval = 0; m_dseq = 0;
  endtask

  task automatic do_reset();
    mac_rx_dvld = 0; mac_rx_data = 0; mac_rx_goodframe = 0; mac_rx_badframe = 0;
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
    tick();
    model_clear();
  endtask

  task automatic score(input string tag, input int p0, input int exp_p);
    check({tag, " pulses"}, 64'(pulses - p0), 64'(exp_p));
    check({tag, " cnt_ok"}, cnt_ok, m_ok);
    check({tag, " cnt_drop"}, cnt_drop, m_drop);
    check({tag, " cnt_bad"}, cnt_bad, m_bad);
    check({tag, " delay_value"}, delay_value, m_dval);
    check({tag, " delay_seq"}, delay_seq, m_dseq);
  endtask

  // short=1: leave the FSM waiting for status so the next frame follows back-to-back
  task automatic send(input int status, input logic [31:0] lt0, input string tag, input bit short = 0);
    int p0, exp_p;
    p0 = pulses;
    exp_p = model(status, lt0);
    local_time = lt0;
    foreach (frm[i]) begin
      mac_rx_dvld = 1; mac_rx_data = frm[i];
      tick();
    end
    mac_rx_dvld = 0; mac_rx_data = 0;
    repeat (2) tick();
    if (short) return;
    if (status == ST_NONE) begin
      repeat (24) tick();
    end else begin
      mac_rx_goodframe = (status == ST_GOOD || status == ST_BOTH);
      mac_rx_badframe  = (status == ST_BAD  || status == ST_BOTH);
      tick();
      mac_rx_goodframe = 0; mac_rx_badframe = 0;
      tick();
      check({tag, " valid latency"}, delay_valid, exp_p);
    end
    repeat (3) tick();
    score(tag, p0, exp_p);
  endtask

  initial begin
    int st, r, plen, n;
    logic [47:0] dst, src;
    logic [15:0] typ;

    model_clear();
    tick();
    check("reset delay_value", delay_value, 0);
    check("reset delay_valid", delay_valid, 0);
    check("reset counters", {cnt_ok, cnt_drop, cnt_bad}, 0);
    do_reset();

    build(LOCAL, PEER, 16'h88B5, 16'h0005, 32'h00000100, 8);
    send(ST_GOOD, 32'h00000180, "t1 good");
    check("t1 delay_value", delay_value, 32'h80);
    check("t1 delay_seq", delay_seq, 16'h5);
    check("t1 cnt_ok", cnt_ok, 1);

    build(LOCAL, PEER, 16'h88B5, 16'h0006, 32'hFFFFFFF0, 4);
    send(ST_GOOD, 32'h00000010, "t2 wrap");
    check("t2 delay_value", delay_value, 32'h20);

    do_reset();
    build(48'h004e46324399, PEER, 16'h88B5, 16'h0007, 32'h1, 6);
    send(ST_GOOD, 32'h100, "t3 dst");
    check("t3 cnt_drop dst", cnt_drop, 1);
    build(LOCAL, PEER, 16'h0800, 16'h0007, 32'h1, 6);
    send(ST_GOOD, 32'h100, "t3 type");
    check("t3 cnt_drop type", cnt_drop, 2);

    do_reset();
    build(LOCAL, PEER, 16'h88B5, 16'h0008, 32'h40, 5);
    send(ST_BOTH, 32'h50, "t4 bad");
    check("t4 cnt_bad", cnt_bad, 1);

    do_reset();
    build(LOCAL, PEER, 16'h88B5, 16'h0009, 32'h40, 5);
    while (frm.size() > 10) void'(frm.pop_back());
    send(ST_NONE, 32'h50, "t5 runt");
    check("t5 cnt_drop", cnt_drop, 1);
    build(LOCAL, PEER, 16'h88B5, 16'h000A, 32'h1000, 3);
    send(ST_GOOD, 32'h1234, "t5 after");
    check("t5 delay_value", delay_value, 32'h234);

    do_reset();
    build(LOCAL, 48'h004e46324302, 16'h88B5, 16'h000B, 32'h10, 4);
    send(ST_GOOD, 32'h30, "t6 src");
`ifdef RX_SRC_FILTER_EN
    check("t6 cnt_drop", cnt_drop, 1);
`else
    check("t6 cnt_ok", cnt_ok, 1);
`endif

    // runt left waiting for status, next frame starts while still in WAIT_STATUS
    do_reset();
    build(LOCAL, PEER, 16'h88B5, 16'h000C, 32'h10, 4);
    while (frm.size() > 9) void'(frm.pop_back());
    send(ST_NONE, 32'h20, "b2b runt", 1);
    build(LOCAL, PEER, 16'h88B5, 16'h000D, 32'h500, 4);
    send(ST_GOOD, 32'h777, "b2b good");

    do_reset();
    for (int k = 0; k < 60; k++) begin
      r   = $urandom_range(0, 3);
      dst = (r != 0) ? LOCAL : {40'h004e463243, 8'($urandom_range(0, 255))};
      r   = $urandom_range(0, 4);
      typ = (r < 4) ? 16'h88B5 : ((r == 4 && $urandom_range(0, 1) == 1) ? 16'h0800 : 16'h86DD);
      src = ($urandom_range(0, 4) != 0) ? PEER : 48'h004e46324302;
      plen = $urandom_range(0, 12);
      build(dst, src, typ, 16'($urandom), 32'($urandom), plen);
      if ($urandom_range(0, 6) == 0) begin
        n = $urandom_range(1, 19);
        while (frm.size() > n) void'(frm.pop_back());
      end
      r  = $urandom_range(0, 19);
      st = (r < 12) ? ST_GOOD : (r < 15) ? ST_BAD : (r < 17) ? ST_BOTH : ST_NONE;
      send(st, 32'($urandom), "rand");
    end

    // reset in the middle of the timestamp field
    build(LOCAL, PEER, 16'h88B5, 16'h00EE, 32'h10, 0);
    send(ST_GOOD, 32'h99, "pre-reset");
    build(LOCAL, PEER, 16'h88B5, 16'h00EF, 32'h11223344, 10);
    local_time = 32'h55667788;
    for (int i = 0; i < 18; i++) begin
      mac_rx_dvld = 1; mac_rx_data = frm[i];
      tick();
    end
    reset_n = 0;
    #1;
    check("midrst delay_value", delay_value, 0);
    check("midrst delay_seq", delay_seq, 0);
    check("midrst delay_valid", delay_valid, 0);
    check("midrst cnt_ok", cnt_ok, 0);
    check("midrst cnt_drop", cnt_drop, 0);
    check("midrst cnt_bad", cnt_bad, 0);
    mac_rx_dvld = 0; mac_rx_data = 0;
    tick(); tick();
    reset_n = 1;
    model_clear();
    repeat (18) void'(frm.pop_front());
    send(ST_GOOD, 32'h1, "midrst rest");
    check("midrst rest cnt_drop", cnt_drop, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
